display_text_parser: RTL and testbench

//  Inverse of the display formatter: consumes a byte-serial ASCII character stream and rebuilds
//  the 32-bit value in hex, decimal, binary or raw-ASCII format. Sits on the console/UART RX path.

---
 rtl/display_text_parser.sv | 223 ++++++++++++++++++++++
 tb/tb_display_text_parser.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_text_parser.sv
`default_nettype none
// ============================================================================
// Module      : display_text_parser
// Description : Byte-serial ASCII to 32-bit value parser. Rebuilds a value from
//               a hex, decimal, binary or raw-ASCII (4 byte) character field.
//               Ingress is valid/ready; results are a one-cycle done/error
//               pulse with data_out held between successes.
//               Build option PARSER_SIGN_EN: accept one leading '-' in decimal
//               mode and return the two's-complement result.
// Revision    : 1.0 - initial release
// ============================================================================
module display_text_parser #(
  parameter logic [7:0]  TERM_CHAR      = 8'h0A,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  format_sel,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        parse_error,
  output logic        parse_busy
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] FMT_HEX = 2'b00;
  localparam logic [1:0] FMT_DEC = 2'b01;
  localparam logic [1:0] FMT_BIN = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PARSE = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          acc_q, acc_d;
  logic [31:0]          data_out_q, data_out_d;
  logic [5:0]           count_q, count_d;
  logic [1:0]           fmt_q, fmt_d;
  logic [TIMER_W-1:0]   timer_q, timer_d, timer_inc;

  logic        accept;
  logic        is_term;
  logic        is_dig;
  logic        is_af;
  logic [3:0]  nib;
  logic        nib_ok;
  logic [35:0] dec_sum;
  logic        dec_ovf;
  logic [31:0] digit_acc;
  logic [31:0] final_val;
  logic [5:0]  max_count;

`ifdef PARSER_SIGN_EN
  logic neg_q, neg_d;
  logic sign_accept;
`endif

  assign accept    = char_valid & char_ready;
  assign is_term   = (char_in == TERM_CHAR);
  assign is_dig    = (char_in >= 8'h30) && (char_in <= 8'h39);
  assign is_af     = ((char_in >= 8'h61) && (char_in <= 8'h66)) ||
                     ((char_in >= 8'h41) && (char_in <= 8'h46));
  assign timer_inc = timer_q + TIMER_W'(1);

  // acc*10 + digit, kept 36 bits wide so a 10th digit cannot wrap silently
  assign dec_sum = ({4'd0, acc_q} << 3) + ({4'd0, acc_q} << 1) + {32'd0, nib};

`ifdef PARSER_SIGN_EN
  assign sign_accept = (fmt_q == FMT_DEC) && (char_in == 8'h2D) && (count_q == 6'd0) && !neg_q;
  assign dec_ovf     = (dec_sum[35:32] != 4'd0) || (neg_q && (dec_sum[31:0] > 32'h8000_0000));
  assign final_val   = neg_q ? (32'd0 - acc_q) : acc_q;
`else
  assign dec_ovf     = (dec_sum[35:32] != 4'd0);
  assign final_val   = acc_q;
`endif

  // Character classification: digit value and legality for the latched format
  always_comb begin
    nib       = char_in[3:0];
    nib_ok    = 1'b0;
    max_count = 6'd4;
    case (fmt_q)
      FMT_HEX: begin
        nib_ok    = is_dig | is_af;
        max_count = 6'd8;
        if (is_af) nib = char_in[3:0] + 4'd9;
      end
      FMT_DEC: begin
        nib_ok    = is_dig;
        max_count = 6'd10;
      end
      FMT_BIN: begin
        nib_ok    = (char_in == 8'h30) || (char_in == 8'h31);
        max_count = 6'd32;
      end
      default: begin
        nib_ok    = 1'b0;
        max_count = 6'd4;
      end
    endcase
  end

  // Accumulator value after shifting in the current character
  always_comb begin
    digit_acc = acc_q;
    case (fmt_q)
      FMT_HEX: digit_acc = {acc_q[27:0], nib};
      FMT_DEC: digit_acc = dec_sum[31:0];
      FMT_BIN: digit_acc = {acc_q[30:0], nib[0]};
      default: digit_acc = {acc_q[23:0], char_in};
    endcase
  end

  // Next-state and datapath update for the parse FSM
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    fmt_d      = fmt_q;
    timer_d    = timer_q;
    data_out_d = data_out_q;
`ifdef PARSER_SIGN_EN
    neg_d      = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PARSE;
          fmt_d   = format_sel;
          acc_d   = 32'd0;
          count_d = 6'd0;
          timer_d = '0;
`ifdef PARSER_SIGN_EN
          neg_d   = 1'b0;
`endif
        end
      end
      S_PARSE: begin
        if (accept) begin
          timer_d = '0;
          if (fmt_q == 2'b11) begin
            // raw ASCII: every byte is data, the 4th one completes the word
            acc_d   = digit_acc;
            count_d = count_q + 6'd1;
            if (count_q == 6'd3) begin
              state_d    = S_DONE;
              data_out_d = digit_acc;
            end
          end else if (is_term) begin
            if (count_q == 6'd0) begin
              state_d = S_DRAIN;
            end else begin
              state_d    = S_DONE;
              data_out_d = final_val;
            end
          end
`ifdef PARSER_SIGN_EN
          else if (sign_accept) begin
            neg_d = 1'b1;
          end
`endif
          else if (!nib_ok || (count_q == max_count) || ((fmt_q == FMT_DEC) && dec_ovf)) begin
            state_d = S_DRAIN;
          end else begin
            acc_d   = digit_acc;
            count_d = count_q + 6'd1;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          timer_d = timer_inc;
          if (timer_inc == TIMER_W'(TIMEOUT_CYCLES)) state_d = S_ERR;
        end
      end
      S_DRAIN: begin
        if (accept && is_term) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= 32'd0;
      data_out_q <= 32'd0;
      count_q    <= 6'd0;
      fmt_q      <= 2'b00;
      timer_q    <= '0;
`ifdef PARSER_SIGN_EN
      neg_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      data_out_q <= data_out_d;
      count_q    <= count_d;
      fmt_q      <= fmt_d;
      timer_q    <= timer_d;
`ifdef PARSER_SIGN_EN
      neg_q      <= neg_d;
`endif
    end
  end

  assign char_ready  = (state_q == S_PARSE) || (state_q == S_DRAIN);
  assign parse_busy  = (state_q == S_PARSE) || (state_q == S_DRAIN);
  assign data_valid  = (state_q == S_DONE);
  assign parse_error = (state_q == S_ERR);
  assign data_out    = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_display_text_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_text_parser
// Description : Randomized scoreboard bench for display_text_parser. A value
//               model computes each field's outcome from the character list;
//               a monitor pops and compares on every done/error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_text_parser;

  localparam logic [7:0]  TERM = 8'h0A;
  localparam int unsigned TMO  = 16;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic        ok;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  format_sel = 2'b00;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [31:0] data_out;
  logic        data_valid;
  logic        parse_error;
  logic        parse_busy;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_good = 32'd0;

  display_text_parser #(
    .TERM_CHAR      (TERM),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .format_sel  (format_sel),
    .char_in     (char_in),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parse_error (parse_error),
    .parse_busy  (parse_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bq_t s2q(input string s);
    bq_t r;
    for (int i = 0; i < s.len(); i++) r.push_back(s[i]);
    return r;
  endfunction

  function automatic int digit_value(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  // Outcome of a whole field, computed numerically from the character list
  function automatic void model(input logic [1:0] fmt, input bq_t q,
                                output logic ok, output logic [31:0] val);
    longint unsigned v;
    int n, d, base, maxd;
    bit err, neg;
    logic [7:0] c;
    v = 0; n = 0; err = 0; neg = 0;
    ok  = 1'b0;
    val = last_good;
    if (fmt == 2'b11) begin
      ok  = 1'b1;
      val = {q[0], q[1], q[2], q[3]};
      return;
    end
    base = (fmt == 2'b00) ? 16 : (fmt == 2'b01) ? 10 : 2;
    maxd = (fmt == 2'b00) ? 8  : (fmt == 2'b01) ? 10 : 32;
    foreach (q[i]) begin
      c = q[i];
      if (c == TERM) begin
        if (err) return;
        if (n == 0) err = 1;
        else begin
          ok  = 1'b1;
          val = neg ? (32'd0 - v[31:0]) : v[31:0];
          return;
        end
      end else if (!err) begin
        d = digit_value(c);
`ifdef PARSER_SIGN_EN
        if (fmt == 2'b01 && c == "-" && n == 0 && !neg) begin
          neg = 1;
          continue;
        end
`endif
        if (d < 0 || d >= base || n == maxd) err = 1;
        else begin
          v = v * longint'(base) + longint'(d);
          n++;
          if (v > 64'hFFFF_FFFF || (neg && v > 64'h8000_0000)) err = 1;
        end
      end
    end
  endfunction

  // Scoreboard monitor: every done/error pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (data_valid || parse_error)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got valid=%b error=%b with empty queue at %0t",
                 data_valid, parse_error, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", {30'd0, data_valid, parse_error}, mon_e.ok ? 32'd2 : 32'd1);
        check("data_out", data_out, mon_e.val);
        check("busy_ready_in_pulse", {30'd0, parse_busy, char_ready}, 32'd0);
      end
    end
  end

  task automatic send_field(input logic [1:0] fmt, input bq_t q, input int gap_max);
    exp_t e;
    int   w;
    model(fmt, q, e.ok, e.val);
    if (e.ok) last_good = e.val;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    format_sel = fmt;
    @(negedge clk);
    start = 1'b0;
    format_sel = 2'($urandom);
    foreach (q[i]) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      char_in = q[i];
      char_valid = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        start = 1'b1;
        format_sel = 2'($urandom);
      end
      w = 0;
      while (!char_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("char_ready_in_field", {31'd0, char_ready}, 32'd1);
      @(negedge clk);
      char_valid = 1'b0;
      start = 1'b0;
      char_in = 8'($urandom);
    end
    check("result_latency", {31'd0, data_valid | parse_error}, 32'd1);
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL result_missing: %0d expectation(s) never answered", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic send_str(input logic [1:0] fmt, input string s, input bit term, input int gap);
    bq_t q;
    q = s2q(s);
    if (term) q.push_back(TERM);
    send_field(fmt, q, gap);
  endtask

  task automatic timeout_test();
    exp_t e;
    int   n;
    e.ok  = 1'b0;
    e.val = last_good;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    format_sel = 2'b01;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (parse_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("timeout_busy_cycles", n, TMO);
    check("timeout_error_pulse", {31'd0, parse_error}, 32'd1);
    @(negedge clk);
    check("timeout_queue_empty", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic reset_mid_field();
    @(negedge clk);
    start = 1'b1;
    format_sel = 2'b00;
    @(negedge clk);
    start = 1'b0;
    char_in = "7";
    char_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_data_out", data_out, 32'd0);
    check("midreset_flags", {28'd0, data_valid, parse_error, parse_busy, char_ready}, 32'd0);
    @(negedge clk);
    char_valid = 1'b0;
    rst_n = 1'b1;
    last_good = 32'd0;
    @(negedge clk);
  endtask

  initial begin
    bq_t  q;
    string alpha;
    string illeg;
    logic [1:0] fmt;
    int nd, maxd;

    repeat (3) @(negedge clk);
    check("reset_data_out", data_out, 32'd0);
    check("reset_flags", {28'd0, data_valid, parse_error, parse_busy, char_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send_str(2'b00, "ABCD1234", 1'b1, 0);
    send_str(2'b01, "987654321", 1'b1, 0);
    send_str(2'b01, "4294967296", 1'b1, 0);
    send_str(2'b10, "10101010110011001111000010101010", 1'b1, 0);
    send_str(2'b10, "101010101100110011110000101010101", 1'b1, 0);
    send_str(2'b11, "Helo", 1'b0, 0);
    send_str(2'b00, "deadBEEF", 1'b1, 3);
    send_str(2'b01, "-1", 1'b1, 0);
    send_str(2'b01, "1-", 1'b1, 0);
    send_str(2'b01, "4294967295", 1'b1, 1);
    send_str(2'b00, "12G4", 1'b1, 0);
    send_str(2'b11, "\n\nab", 1'b0, 2);

    illeg = "gGxz.-+ ";
    for (int k = 0; k < 60; k++) begin
      fmt = 2'($urandom_range(0, 3));
      q.delete();
      if (fmt == 2'b11) begin
        repeat (4) q.push_back(8'($urandom));
      end else begin
        alpha = (fmt == 2'b00) ? "0123456789abcdefABCDEF" :
                (fmt == 2'b01) ? "0123456789" : "01";
        maxd  = (fmt == 2'b00) ? 8 : (fmt == 2'b01) ? 10 : 32;
        nd    = $urandom_range(1, maxd + 1);
        for (int i = 0; i < nd; i++) begin
          if ($urandom_range(0, 24) == 0) q.push_back(illeg[$urandom_range(0, illeg.len() - 1)]);
          else q.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
        end
        q.push_back(TERM);
      end
      send_field(fmt, q, 3);
    end

    timeout_test();
    reset_mid_field();
    send_str(2'b00, "1F", 1'b1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
